// File: rtl/kernel_led_pattern_pkg.sv
// Shared types and constants for the LED pattern kernel.
package kernel_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_SHIFT  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PATTERN = 3'd2;
    localparam logic [2:0] ADDR_COUNT   = 3'd3;
    localparam logic [2:0] ADDR_DUTY    = 3'd4;
    localparam logic [2:0] ADDR_STEPS   = 3'd5;

    localparam int unsigned CTRL_MODE_LO = 0;
    localparam int unsigned CTRL_MODE_HI = 1;
    localparam int unsigned CTRL_IRQ_EN  = 2;
    localparam int unsigned CTRL_START   = 3;
    localparam int unsigned CTRL_STOP    = 4;
    localparam int unsigned CTRL_CONT    = 5;

endpackage

// File: rtl/kernel_led_pattern_if.sv
// Avalon-MM slave bus for the LED pattern kernel.
interface kernel_led_pattern_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/kernel_led_pattern_pwm.sv
// Free-running PWM brightness generator; full-scale duty means always on.
module kernel_led_pwm
    import kernel_led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);

    logic [PWM_BITS-1:0] p;

    // Counter wraps naturally from all-ones back to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            p <= '0;
        end else begin
            p <= p + PWM_BITS'(1);
        end
    end

    assign pwm_on = (p < duty) | (duty == '1);

endmodule

// File: rtl/kernel_led_pattern.sv
// LED pattern kernel: register file, run FSM, pattern stepping and LED drive.
module kernel_led_pattern
    import kernel_led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    kernel_led_pattern_if.slave  bus,
    input  logic                 tick_in,
    output logic [NUM_LEDS-1:0]  led_out,
    output logic                 irq
);

    state_e               state_q, state_d;
    mode_e                mode_q;
    logic                 irq_en_q;
    logic                 cont_q;
    logic [NUM_LEDS-1:0]  pattern_q;
    logic [15:0]          count_q;
    logic [PWM_BITS-1:0]  duty_q;
    logic [NUM_LEDS-1:0]  frame_q;
    logic [NUM_LEDS-1:0]  frame_rot;
    logic                 phase_q;
    logic [15:0]          steps_left_q;
    logic                 done_q;
    logic [15:0]          readdata_q;
    logic [15:0]          rd_mux;
    logic [NUM_LEDS-1:0]  led_d;
    logic                 pwm_on;

    logic wr;
    logic wr_status, wr_control, wr_pattern, wr_count, wr_duty;
    logic start_req, stop_req;
    logic load_run, step, last_step;
    logic busy;

    assign wr         = bus.chipselect & ~bus.write_n;
    assign wr_status  = wr && (bus.address == ADDR_STATUS);
    assign wr_control = wr && (bus.address == ADDR_CONTROL);
    assign wr_pattern = wr && (bus.address == ADDR_PATTERN);
    assign wr_count   = wr && (bus.address == ADDR_COUNT);
    assign wr_duty    = wr && (bus.address == ADDR_DUTY);
    assign start_req  = wr_control & bus.writedata[CTRL_START];
    assign stop_req   = wr_control & bus.writedata[CTRL_STOP];
    assign busy       = (state_q == ST_RUN);

    assign bus.readdata = readdata_q;
    assign irq          = done_q & irq_en_q;

    generate
        if (NUM_LEDS > 1) begin : g_rot
            assign frame_rot = {frame_q[NUM_LEDS-2:0], frame_q[NUM_LEDS-1]};
        end else begin : g_norot
            assign frame_rot = frame_q;
        end
    endgenerate

    kernel_led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .duty   (duty_q),
        .pwm_on (pwm_on)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and step decode; start beats both stop and a coincident tick
    always_comb begin
        state_d   = state_q;
        load_run  = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d  = ST_RUN;
                    load_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_req) begin
                    load_run = 1'b1;
                end else if (stop_req) begin
                    state_d = ST_IDLE;
                end else if (tick_in) begin
                    step = 1'b1;
                    if ((count_q != '0) && (steps_left_q == 16'd1)) begin
                        last_step = 1'b1;
                        if (!cont_q) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Host-writable configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_OFF;
            irq_en_q  <= 1'b0;
            cont_q    <= 1'b0;
            pattern_q <= NUM_LEDS'(1);
            count_q   <= '0;
            duty_q    <= '1;
        end else begin
            if (wr_control) begin
                mode_q   <= mode_e'(bus.writedata[CTRL_MODE_HI:CTRL_MODE_LO]);
                irq_en_q <= bus.writedata[CTRL_IRQ_EN];
                cont_q   <= bus.writedata[CTRL_CONT];
            end
            if (wr_pattern) begin
                pattern_q <= bus.writedata[NUM_LEDS-1:0];
            end
            if (wr_count) begin
                count_q <= bus.writedata;
            end
            if (wr_duty) begin
                duty_q <= bus.writedata[PWM_BITS-1:0];
            end
        end
    end

    // Live frame, blink phase, step counter and done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q      <= NUM_LEDS'(1);
            phase_q      <= 1'b1;
            steps_left_q <= '0;
            done_q       <= 1'b0;
        end else begin
            if (load_run) begin
                frame_q <= pattern_q;
            end else if (wr_pattern) begin
                frame_q <= bus.writedata[NUM_LEDS-1:0];
            end else if (step && (mode_q == MODE_SHIFT)) begin
                frame_q <= frame_rot;
            end

            if (load_run) begin
                phase_q <= 1'b1;
            end else if (step && (mode_q == MODE_BLINK)) begin
                phase_q <= ~phase_q;
            end

            if (load_run) begin
                steps_left_q <= count_q;
            end else if (step && (count_q != '0)) begin
                if (last_step && cont_q) begin
                    steps_left_q <= count_q;
                end else if (steps_left_q != '0) begin
                    steps_left_q <= steps_left_q - 16'd1;
                end
            end

            if (last_step) begin
                done_q <= 1'b1;
            end else if (wr_status) begin
                done_q <= 1'b0;
            end
        end
    end

    // LED drive: visible frame gated by PWM and, in blink mode, the phase
    always_comb begin
        led_d = '0;
        if (state_q == ST_RUN) begin
            if (mode_q != MODE_OFF) begin
                led_d = frame_q & {NUM_LEDS{pwm_on & ((mode_q != MODE_BLINK) | phase_q)}};
            end
        end
    end

    // Read mux; unused bits and addresses return zero
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_STATUS: begin
                rd_mux[1] = busy;
                rd_mux[0] = done_q;
            end
            ADDR_CONTROL: begin
                rd_mux[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
                rd_mux[CTRL_IRQ_EN]               = irq_en_q;
                rd_mux[CTRL_CONT]                 = cont_q;
            end
            ADDR_PATTERN: rd_mux[NUM_LEDS-1:0] = pattern_q;
            ADDR_COUNT:   rd_mux               = count_q;
            ADDR_DUTY:    rd_mux[PWM_BITS-1:0] = duty_q;
            ADDR_STEPS:   rd_mux               = steps_left_q;
            default:      rd_mux               = '0;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
            led_out    <= '0;
        end else begin
            readdata_q <= rd_mux;
            led_out    <= led_d;
        end
    end

endmodule

// File: tb/tb_kernel_led_pattern.sv
// Scoreboard bench for kernel_led_pattern: driver queues expectations, monitor checks.
module tb_kernel_led_pattern;
    import kernel_led_pkg::*;

    localparam int NUM_LEDS = 4;
    localparam int PWM_BITS = 8;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                tick_in = 1'b0;
    logic [NUM_LEDS-1:0] led_out;
    logic                irq;

    logic rd_chk = 1'b0, led_chk = 1'b0, irq_chk = 1'b0;
    logic cnt_en = 1'b0, cnt_clr = 1'b0, cnt_chk = 1'b0;
    logic rd_chk_q = 1'b0, led_chk_q = 1'b0, irq_chk_q = 1'b0;
    logic cnt_en_q = 1'b0, cnt_clr_q = 1'b0, cnt_chk_q = 1'b0;

    exp_t q_rd[$];
    exp_t q_led[$];
    exp_t q_irq[$];
    exp_t q_cnt[$];
    int   ones[NUM_LEDS];
    int   n_tests = 0;
    int   n_fail  = 0;

    kernel_led_pattern_if bus ();

    kernel_led_pattern #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .tick_in (tick_in),
        .led_out (led_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void sb_empty(string which);
        n_tests++;
        n_fail++;
        $display("FAIL sb_%s: output presented with no expectation queued", which);
    endfunction

    // Check requests are registered so the monitor looks at the edge they were raised for
    always @(posedge clk) begin
        rd_chk_q  <= rd_chk;
        led_chk_q <= led_chk;
        irq_chk_q <= irq_chk;
        cnt_en_q  <= cnt_en;
        cnt_clr_q <= cnt_clr;
        cnt_chk_q <= cnt_chk;
    end

    // Monitor: compare DUT outputs just after each active edge
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (rd_chk_q) begin
            if (q_rd.size() == 0) sb_empty("rd");
            else begin e = q_rd.pop_front(); check(e.name, bus.readdata, e.val); end
        end
        if (led_chk_q) begin
            if (q_led.size() == 0) sb_empty("led");
            else begin e = q_led.pop_front(); check(e.name, 16'(led_out), e.val); end
        end
        if (irq_chk_q) begin
            if (q_irq.size() == 0) sb_empty("irq");
            else begin e = q_irq.pop_front(); check(e.name, 16'(irq), e.val); end
        end
        if (cnt_clr_q) begin
            for (int i = 0; i < NUM_LEDS; i++) ones[i] = 0;
        end
        if (cnt_en_q) begin
            for (int i = 0; i < NUM_LEDS; i++) ones[i] += int'(led_out[i]);
        end
        if (cnt_chk_q) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (q_cnt.size() == 0) sb_empty("cnt");
                else begin e = q_cnt.pop_front(); check(e.name, 16'(ones[i]), e.val); end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick_in = 1'b0;
        rd_chk  = 1'b0;
        led_chk = 1'b0;
        irq_chk = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        cnt_chk = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        cycle();
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
        bus.address = a;
        rd_chk = 1'b1;
        q_rd.push_back('{name: n, val: e});
        cycle();
    endtask

    task automatic exp_led(input logic [15:0] e, input string n);
        led_chk = 1'b1;
        q_led.push_back('{name: n, val: e});
    endtask

    task automatic exp_irq(input logic [15:0] e, input string n);
        irq_chk = 1'b1;
        q_irq.push_back('{name: n, val: e});
    endtask

    task automatic tick();
        tick_in = 1'b1;
        cycle();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        @(negedge clk);

        // Reset state
        reset = 1'b1;
        cycle();
        exp_led(16'h0, "rst_led");
        exp_irq(16'h0, "rst_irq");
        rd(ADDR_PATTERN, 16'h0, "rst_readdata");
        reset = 1'b0;
        rd(ADDR_STATUS,  16'h0,  "rst_status");
        rd(ADDR_CONTROL, 16'h0,  "rst_control");
        rd(ADDR_PATTERN, 16'h1,  "rst_pattern");
        rd(ADDR_COUNT,   16'h0,  "rst_count");
        rd(ADDR_DUTY,    16'hFF, "rst_duty");
        rd(ADDR_STEPS,   16'h0,  "rst_steps");

        // 1: shift with count 3 and irq
        wr(ADDR_DUTY, 16'hFF);
        wr(ADDR_COUNT, 16'd3);
        wr(ADDR_PATTERN, 16'h1);
        wr(ADDR_CONTROL, 16'h000F);
        exp_led(16'h1, "t1_led_a");
        rd(ADDR_STATUS, 16'h2, "t1_busy");
        tick();
        exp_led(16'h2, "t1_led_b");
        rd(ADDR_STEPS, 16'd2, "t1_steps");
        tick();
        exp_led(16'h4, "t1_led_c");
        rd(ADDR_STATUS, 16'h2, "t1_busy2");
        tick();
        exp_led(16'h0, "t1_led_idle");
        exp_irq(16'h1, "t1_irq");
        rd(ADDR_STATUS, 16'h1, "t1_status_done");
        exp_irq(16'h0, "t1_irq_clr");
        wr(ADDR_STATUS, 16'h0);
        rd(ADDR_STATUS, 16'h0, "t1_status_clr");

        // 2: blink forever
        wr(ADDR_PATTERN, 16'hF);
        wr(ADDR_COUNT, 16'd0);
        wr(ADDR_CONTROL, 16'h000A);
        exp_led(16'hF, "t2_led0");
        cycle();
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_led((i % 2 == 0) ? 16'h0 : 16'hF, $sformatf("t2_led%0d", i + 1));
            cycle();
        end
        rd(ADDR_STATUS, 16'h2, "t2_status");
        rd(ADDR_STEPS, 16'h0, "t2_steps");
        wr(ADDR_CONTROL, 16'h0010);
        exp_led(16'h0, "t2_stop_led");
        cycle();

        // 3: static pattern at quarter brightness
        wr(ADDR_DUTY, 16'h40);
        wr(ADDR_PATTERN, 16'h5);
        wr(ADDR_CONTROL, 16'h0009);
        cycle();
        cycle();
        cnt_clr = 1'b1;
        cycle();
        for (int i = 0; i < 256; i++) begin
            cnt_en = 1'b1;
            cycle();
        end
        q_cnt.push_back('{name: "t3_bit0_on", val: 16'd64});
        q_cnt.push_back('{name: "t3_bit1_on", val: 16'd0});
        q_cnt.push_back('{name: "t3_bit2_on", val: 16'd64});
        q_cnt.push_back('{name: "t3_bit3_on", val: 16'd0});
        cnt_chk = 1'b1;
        cycle();
        wr(ADDR_CONTROL, 16'h0010);

        // 4: continuous reload
        wr(ADDR_DUTY, 16'hFF);
        wr(ADDR_COUNT, 16'd2);
        wr(ADDR_CONTROL, 16'h0029);
        rd(ADDR_STEPS, 16'd2, "t4_steps0");
        tick();
        rd(ADDR_STEPS, 16'd1, "t4_steps1");
        rd(ADDR_STATUS, 16'h2, "t4_not_done");
        tick();
        rd(ADDR_STEPS, 16'd2, "t4_steps2");
        rd(ADDR_STATUS, 16'h3, "t4_done_busy");
        tick();
        rd(ADDR_STEPS, 16'd1, "t4_steps3");
        tick();
        rd(ADDR_STEPS, 16'd2, "t4_steps4");
        rd(ADDR_STATUS, 16'h3, "t4_busy4");

        // 5: corner cases
        wr(ADDR_COUNT, 16'd5);
        rd(ADDR_STEPS, 16'd2, "t5_count_no_reload");
        tick_in = 1'b1;
        wr(ADDR_CONTROL, 16'h0029);
        rd(ADDR_STEPS, 16'd5, "t5_tick_with_start");
        wr(ADDR_CONTROL, 16'h0011);
        rd(ADDR_STATUS, 16'h1, "t5_stopped");
        tick();
        rd(ADDR_STEPS, 16'd5, "t5_idle_tick");
        wr(ADDR_CONTROL, 16'h0019);
        rd(ADDR_STATUS, 16'h3, "t5_start_stop");
        wr(ADDR_CONTROL, 16'h002D);
        exp_led(16'h5, "t5_run_led");
        exp_irq(16'h1, "t5_run_irq");
        cycle();
        reset = 1'b1;
        exp_led(16'h0, "t5_rst_led");
        exp_irq(16'h0, "t5_rst_irq");
        rd(ADDR_STEPS, 16'h0, "t5_rst_readdata");
        reset = 1'b0;
        exp_led(16'h0, "t5_post_led");
        rd(ADDR_STATUS,  16'h0,  "t5_rst_status");
        rd(ADDR_CONTROL, 16'h0,  "t5_rst_control");
        rd(ADDR_PATTERN, 16'h1,  "t5_rst_pattern");
        rd(ADDR_COUNT,   16'h0,  "t5_rst_count");
        rd(ADDR_DUTY,    16'hFF, "t5_rst_duty");
        rd(ADDR_STEPS,   16'h0,  "t5_rst_steps");

        // 6: register readback and unmapped addresses
        wr(ADDR_COUNT, 16'h1234);
        rd(ADDR_COUNT, 16'h1234, "t6_count");
        rd(3'd6, 16'h0, "t6_addr6");
        rd(3'd7, 16'h0, "t6_addr7");
        wr(ADDR_CONTROL, 16'h003E);
        rd(ADDR_CONTROL, 16'h0026, "t6_ctrl_strobes");
        wr(ADDR_CONTROL, 16'h0010);

        // 7: zero duty keeps LEDs dark while running
        wr(ADDR_DUTY, 16'h0);
        wr(ADDR_PATTERN, 16'hF);
        wr(ADDR_CONTROL, 16'h0009);
        for (int i = 0; i < 4; i++) begin
            exp_led(16'h0, $sformatf("t7_duty0_%0d", i));
            cycle();
        end

        cycle();
        cycle();
        check("sb_leftover", 16'(q_rd.size() + q_led.size() + q_irq.size() + q_cnt.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
